// File: rtl/pwm_timer_pkg.sv
// Shared constants for the PWM timer slice.
// Used by clk_divider, main_counter and timer.
package pwm_timer_pkg;

    localparam int DIV_WIDTH = 16;
    localparam int MIN_DIV   = 2;

endpackage

// File: rtl/clk_divider.sv
// Programmable clock divider producing a registered slow_clk and tick from chosen_clk.
// The divisor is shadowed and only reloads at a period boundary, so slow_clk never has a runt phase.
module clk_divider
    import pwm_timer_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             chosen_clk,
    input  logic             rst,
    input  logic             div_en,
    input  logic [WIDTH-1:0] divisor,
    output logic             slow_clk,
    output logic             tick,
    output logic             bypass,
    output logic             div_active
);

    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] N_MIN = WIDTH'(MIN_DIV);

    logic             running;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div_q;

    logic [WIDTH-1:0] neff_cur;
    logic [WIDTH-1:0] neff_new;
    logic [WIDTH-1:0] half_cur;
    logic [WIDTH-1:0] cnt_inc;
    logic             wrap;

    // A zero divisor behaves like divide-by-one.
    assign neff_cur = (div_q == '0)   ? ONE : div_q;
    assign neff_new = (divisor == '0) ? ONE : divisor;

    // ceil(N/2) written so that N = 2^WIDTH-1 does not overflow.
    assign half_cur = (neff_cur >> 1) + WIDTH'(neff_cur[0]);
    assign cnt_inc  = cnt + ONE;
    assign wrap     = running && (cnt == neff_cur - ONE);

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values; blocking here would let later lines see updated state.
    always_ff @(posedge chosen_clk) begin
        if (rst) begin
            running    <= 1'b0;
            cnt        <= '0;
            div_q      <= '0;
            slow_clk   <= 1'b0;
            tick       <= 1'b0;
            bypass     <= 1'b0;
            div_active <= 1'b0;
        end else if (!div_en) begin
            // Stop abandons the period; div_q is kept so a stop on a wrap edge does not reload it.
            running    <= 1'b0;
            cnt        <= '0;
            slow_clk   <= 1'b0;
            tick       <= 1'b0;
            bypass     <= 1'b0;
            div_active <= 1'b0;
        end else if (!running || wrap) begin
            // Start and wrap are both period boundaries: reload the shadow divisor.
            running    <= 1'b1;
            cnt        <= '0;
            div_q      <= divisor;
            tick       <= 1'b1;
            slow_clk   <= (neff_new >= N_MIN);
            bypass     <= (neff_new < N_MIN);
            div_active <= 1'b1;
        end else begin
            // Reaching here implies Neff >= 2, since Neff = 1 wraps on every edge.
            cnt        <= cnt_inc;
            tick       <= 1'b0;
            slow_clk   <= (cnt_inc < half_cur);
        end
    end

endmodule

// File: tb/tb_clk_divider.sv
// Self-checking bench for clk_divider: directed test-plan steps plus a random
// phase, checked against a period-level reference model.
module tb_clk_divider;

    localparam int W = 16;

    logic         chosen_clk = 1'b0;
    logic         rst        = 1'b1;
    logic         div_en     = 1'b0;
    logic [W-1:0] divisor    = '0;
    logic         slow_clk;
    logic         tick;
    logic         bypass;
    logic         div_active;

    int checks = 0;
    int errors = 0;

    // Reference model: whether running, the latched ratio, and the position inside the period.
    bit m_run = 0;
    int m_n   = 0;
    int m_pos = 0;

    clk_divider #(.WIDTH(W)) dut (
        .chosen_clk (chosen_clk),
        .rst        (rst),
        .div_en     (div_en),
        .divisor    (divisor),
        .slow_clk   (slow_clk),
        .tick       (tick),
        .bypass     (bypass),
        .div_active (div_active)
    );

    always #5 chosen_clk = ~chosen_clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic int eff(input logic [W-1:0] d);
        return (d == '0) ? 1 : int'(d);
    endfunction

    // Advance the model by one chosen_clk edge using the inputs present at that edge.
    task automatic model_edge();
        if (rst) begin
            m_run = 0;
            m_pos = 0;
            m_n   = 0;
        end else if (!div_en) begin
            m_run = 0;
            m_pos = 0;
        end else if (!m_run || m_pos == m_n - 1) begin
            m_run = 1;
            m_pos = 0;
            m_n   = eff(divisor);
        end else begin
            m_pos++;
        end
    endtask

    // One edge, then compare every output against the model away from the edge.
    task automatic step();
        bit exp_slow;
        @(posedge chosen_clk);
        model_edge();
        #1;
        exp_slow = m_run && (m_n >= 2) && (m_pos < (m_n + 1) / 2);
        check("slow_clk",   32'(slow_clk),   32'(exp_slow));
        check("tick",       32'(tick),       32'(m_run && m_pos == 0));
        check("bypass",     32'(bypass),     32'(m_run && m_n < 2));
        check("div_active", 32'(div_active), 32'(m_run));
    endtask

    task automatic expect_all_low(input string tag);
        check({tag, "_slow"},   32'(slow_clk),   0);
        check({tag, "_tick"},   32'(tick),       0);
        check({tag, "_bypass"}, 32'(bypass),     0);
        check({tag, "_active"}, 32'(div_active), 0);
    endtask

    initial begin
        logic [5:0] shadow_pat;

        // Reset held with the divider requested; nothing may start.
        div_en  = 1'b1;
        divisor = 16'd4;
        rst     = 1'b1;
        repeat (2) begin
            step();
            expect_all_low("reset");
        end
        rst = 1'b0;
        step();
        check("first_tick_after_reset", 32'(tick), 1);

        // N=4: 1,1,0,0 with tick every 4 cycles (cycle 0 was the step above).
        for (int k = 1; k < 12; k++) begin
            step();
            check("n4_slow", 32'(slow_clk), 32'((k % 4) < 2));
            check("n4_tick", 32'(tick),     32'((k % 4) == 0));
        end

        // N=5: 1,1,1,0,0.
        div_en = 1'b0;
        step();
        divisor = 16'd5;
        div_en  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check("n5_slow", 32'(slow_clk), 32'((k % 5) < 3));
            check("n5_tick", 32'(tick),     32'((k % 5) == 0));
        end

        // Shadowed update: divisor changes to 2 at cnt=1 and must wait for the wrap.
        div_en = 1'b0;
        step();
        divisor = 16'd4;
        div_en  = 1'b1;
        step();
        step();
        divisor    = 16'd2;
        shadow_pat = 6'b010100; // bit k = slow_clk k cycles after the change: 0,0,1,0,1,0
        for (int k = 0; k < 6; k++) begin
            step();
            check("shadow_slow", 32'(slow_clk), 32'(shadow_pat[k]));
        end

        // Bypass: divisor 0 then 1, then back to 3.
        divisor = 16'd0;
        repeat (3) step();
        check("bypass0_flag", 32'(bypass),   1);
        check("bypass0_slow", 32'(slow_clk), 0);
        check("bypass0_tick", 32'(tick),     1);
        divisor = 16'd1;
        repeat (3) step();
        check("bypass1_flag", 32'(bypass), 1);
        divisor = 16'd3;
        for (int k = 0; k < 6; k++) begin
            step();
            check("n3_slow", 32'(slow_clk), 32'((k % 3) < 2));
            check("n3_bypass", 32'(bypass), 0);
        end

        // Stop mid-run at cnt=2, restart, then reset at cnt=4.
        div_en = 1'b0;
        step();
        divisor = 16'd6;
        div_en  = 1'b1;
        repeat (3) step();
        div_en = 1'b0;
        step();
        expect_all_low("stop");
        div_en = 1'b1;
        step();
        check("restart_tick", 32'(tick), 1);
        repeat (4) step();
        rst = 1'b1;
        step();
        expect_all_low("reset_mid");
        rst = 1'b0;
        step();
        check("post_reset_tick", 32'(tick), 1);

        // Largest ratio: high phase must last 32768 cycles without overflow.
        div_en = 1'b0;
        step();
        divisor = 16'hFFFF;
        div_en  = 1'b1;
        repeat (32768) step();
        check("max_high_end", 32'(slow_clk), 1);
        step();
        check("max_fall", 32'(slow_clk), 0);
        div_en = 1'b0;
        step();

        // Random phase: small divisors, occasional stops and resets.
        for (int k = 0; k < 3000; k++) begin
            divisor = 16'($urandom_range(0, 9));
            div_en  = ($urandom_range(0, 19) != 0);
            rst     = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_divider.md
# clk_divider

- Generates the divided clock `slow_clk` and a matching one-cycle `tick` from `chosen_clk`, using a programmable divisor.
- Sits directly upstream of `main_counter`: its `slow_clk` drives the counter's `slow_clk` input, and `tick` is the enable-style equivalent for logic that stays on `chosen_clk`.
- The divisor is shadowed, so changes apply only on period boundaries and never produce a runt or glitched `slow_clk` phase.

## Interface
Parameters:
- `WIDTH`, 16, width of the divisor and of the internal count.

Ports:
- `chosen_clk`  in  1  single clock for the block; every register updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `div_en`  in  1  run enable, sampled on every edge.
- `divisor`  in  WIDTH  requested divide ratio N; takes effect only at a period boundary.
- `slow_clk`  out  1  registered divided clock; high for ceil(N/2) cycles, then low for floor(N/2) cycles.
- `tick`  out  1  registered one-cycle pulse, high in the first cycle of each period.
- `bypass`  out  1  registered; high while the active N < 2 (the upstream mux must then select `chosen_clk` directly).
- `div_active`  out  1  registered; high while the divider is running.

## Operation
- State: `running`, `cnt` (WIDTH bits), `div_q` (shadow of `divisor`, WIDTH bits), and the output registers.
- Effective ratio: Neff = `div_q`, except `div_q` = 0 is treated as 1. H = (Neff+1)>>1.
- Start (`running`=0 and `div_en`=1 at an edge):
  - `div_q` <= `divisor`, `cnt` <= 0, `running` <= 1.
  - `tick` <= 1; `slow_clk` <= (new Neff >= 2).
- Run (`running`=1 and `div_en`=1):
  - If `cnt` = Neff-1: this is a wrap. `cnt` <= 0, `div_q` <= `divisor`, `tick` <= 1.
  - Otherwise: `cnt` <= `cnt`+1, `tick` <= 0.
  - The `slow_clk` register is loaded with (next `cnt` < next H) and next Neff >= 2, so `slow_clk` == (`cnt` < H) at all times.
- Stop (`div_en`=0 at any edge):
  - `running`, `cnt`, `slow_clk`, `tick` <= 0.
  - The current period is abandoned; no completion is attempted.
- Bypass (Neff = 1):
  - `bypass`=1, `slow_clk`=0, `tick`=1 on every running cycle.
  - Every edge is a boundary, so a new `divisor` loads on the next edge.
- Changing `divisor` mid-period has no effect until the wrap edge.
- Arithmetic is unsigned WIDTH-bit. N = 2^WIDTH-1 is legal. Neither `cnt` nor H overflows.

## Timing
- Reset: `slow_clk`=0, `tick`=0, `bypass`=0, `div_active`=0, `cnt`=0, `div_q`=0, `running`=0.
- Priority: `rst` > `div_en`=0 > wrap > increment.
- Latency: one edge from `div_en`=1 to the first `tick` and the first `slow_clk` rise.
- `tick` and the `slow_clk` rise coincide in the same cycle.
- `div_active` = `running`. `bypass` = `running` & (Neff < 2), registered together with `div_q`.
- Simultaneous events:
  - `div_en` falls on a wrap edge: stop wins and `div_q` is not reloaded.
  - `rst` during a run: all state clears at that edge; a restart needs `div_en` high at a later edge.
- `slow_clk` changes only on `chosen_clk` edges and carries no combinational path from inputs.

## Structure
- `WIDTH` default and `MIN_DIV` = 2 go in the shared package `pwm_timer_pkg`, which is also used by `main_counter` and `timer`.
- Single flat module, no sub-module.

## Test plan
- Reset: hold `rst` for 2 cycles with `div_en`=1 and `divisor`=4 -> all outputs 0 throughout; the first `tick` appears one edge after `rst` falls.
- N=4: run 12 cycles -> `slow_clk` 1,1,0,0 repeating; `tick` high at cycles 0, 4, 8; `bypass`=0.
- N=5 (odd): run 10 cycles -> `slow_clk` 1,1,1,0,0 repeating; `tick` every 5 cycles.
- Shadowed update: N=4, write `divisor`=2 at `cnt`=1 -> pattern stays 1,1,0,0 until the wrap, then becomes 1,0; no runt phase.
- Bypass: `divisor`=0, then 1 -> `bypass`=1, `tick`=1 every cycle, `slow_clk`=0; switching to `divisor`=3 gives 1,1,0 from the next edge.
- Stop/reset mid-run: N=6, drop `div_en` at `cnt`=2 -> all outputs 0 at the next edge. Re-enable -> `tick`=1 one edge later with `cnt` starting at 0. `rst` at `cnt`=4 -> same clearing.
